// File: rtl/char_t_if.sv
// Character handshake bundle between upstream logic and the UART transmitter.
// Master drives the character and valid; slave returns ready.
interface char_t_if;
    logic [7:0] i_char;
    logic       i_valid;
    logic       o_ready;

    modport master (
        output i_char,
        output i_valid,
        input  o_ready
    );

    modport slave (
        input  i_char,
        input  i_valid,
        output o_ready
    );
endinterface

// File: rtl/char_t.sv
// 8N1 UART transmitter with a one-entry holding register.
// Back-to-back frames leave no idle cycle when the next character is queued.
module char_t #(
    parameter int CLK_PER_BIT_FAST = 10,
    parameter int CLK_PER_BIT_SLOW = 120,
    parameter int CNT_W            = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_baud,
    char_t_if.slave    bus,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(CLK_PER_BIT_FAST - 1);
    localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(CLK_PER_BIT_SLOW - 1);

    state_t           state;
    logic [7:0]       hold;
    logic             hold_valid;
    logic [7:0]       shift;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] clk_cnt;
    logic [CNT_W-1:0] per_last;

    logic accept;
    logic last;
    logic load;

    assign bus.o_ready = !hold_valid;
    assign accept      = bus.i_valid && !hold_valid;
    assign last        = clk_cnt == per_last;
    assign o_busy      = state != IDLE;

    // Hold is drained either from IDLE or at the final STOP clock.
    assign load = hold_valid &&
                  ((state == IDLE) || (state == STOP && last));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            hold       <= 8'h00;
            hold_valid <= 1'b0;
            shift      <= 8'h00;
            bit_cnt    <= 3'd0;
            clk_cnt    <= '0;
            per_last   <= '0;
            o_tx       <= 1'b1;
            o_done     <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            hold_valid <= accept || (hold_valid && !load);
            if (accept) begin
                hold <= bus.i_char;
            end

            if (load) begin
                state    <= START;
                shift    <= hold;
                bit_cnt  <= 3'd0;
                clk_cnt  <= '0;
                o_tx     <= 1'b0;
                per_last <= i_baud ? LAST_SLOW : LAST_FAST;
            end

            case (state)
                IDLE: begin
                    if (!hold_valid) begin
                        o_tx <= 1'b1;
                    end
                end
                START: begin
                    if (last) begin
                        clk_cnt <= '0;
                        state   <= DATA;
                        o_tx    <= shift[0];
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (last) begin
                        clk_cnt <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            o_tx  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            o_tx    <= shift[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (last) begin
                        o_done <= 1'b1;
                        if (!hold_valid) begin
                            clk_cnt <= '0;
                            state   <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_t.sv
// Bench for char_t: frame-timeline model checked every cycle,
// plus directed timing and ordering expectations.
module tb_char_t;

    logic clk;
    logic rst_n;
    logic baud;
    logic tx;
    logic busy;
    logic done;

    char_t_if bus ();

    char_t dut (
        .i_clk  (clk),
        .i_rst  (rst_n),
        .i_baud (baud),
        .bus    (bus),
        .o_tx   (tx),
        .o_busy (busy),
        .o_done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    int done_t[$];

    // Model: a frame is a start time, a bit period and a byte.
    bit         m_act;
    bit         m_done;
    int         m_el;
    int         m_p;
    logic [7:0] m_byte;
    logic [7:0] m_q[$];
    logic [7:0] sent[$];

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            if (bad < 30)
                $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    function automatic logic exp_tx();
        int k;
        logic [7:0] b;
        if (!m_act) return 1'b1;
        k = m_el / m_p;
        b = m_byte;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        bit acc;
        if (!rst_n) begin
            m_act  = 1'b0;
            m_done = 1'b0;
            m_el   = 0;
            m_p    = 10;
            m_q.delete();
        end else begin
            acc    = bus.i_valid && (m_q.size() == 0);
            m_done = 1'b0;
            if (m_act) begin
                m_el++;
                if (m_el == 10 * m_p) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                end
            end
            if (!m_act && m_q.size() > 0) begin
                m_byte = m_q.pop_front();
                m_p    = baud ? 120 : 10;
                m_el   = 0;
                m_act  = 1'b1;
                sent.push_back(m_byte);
            end
            if (acc) m_q.push_back(bus.i_char);
        end
    end

    always @(negedge clk) begin
        chk("tx", tx, exp_tx());
        chk("busy", busy, m_act);
        chk("ready", bus.o_ready, m_q.size() == 0);
        chk("done", done, m_done);
        if (done) done_t.push_back(cyc);
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_char  = b;
        while (!bus.o_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_ready) chk("send_timeout", 1, 0);
        @(negedge clk);
        acc_cyc     = cyc;
        bus.i_valid = 1'b0;
    endtask

    task automatic stream(input logic [7:0] b[4], input int n);
        int k;
        @(negedge clk);
        bus.i_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.i_char = b[i];
            k = 0;
            while (!bus.o_ready && k < 3000) begin
                @(negedge clk);
                k++;
            end
            if (!bus.o_ready) chk("stream_timeout", i, n);
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int lim);
        int k;
        k = 0;
        while (done_t.size() < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("done_wait", done_t.size() >= n, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int lowcnt;
        logic [7:0] s4[4];

        rst_n       = 1'b0;
        baud        = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_char  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_ready", bus.o_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame, fast baud
        n0 = done_t.size();
        send(8'h55);
        chk("acc_tx_idle", tx, 1);
        chk("acc_ready_low", bus.o_ready, 0);
        @(negedge clk);
        chk("start_bit", tx, 0);
        chk("start_busy", busy, 1);
        repeat (15) @(negedge clk);
        chk("d0_55", tx, 1);
        repeat (10) @(negedge clk);
        chk("d1_55", tx, 0);
        wait_done(n0 + 1, 200);
        chk("single_len", done_t[n0] - acc_cyc, 101);
        chk("single_byte", sent[sent.size()-1], 8'h55);
        repeat (5) @(negedge clk);
        chk("single_one_done", done_t.size(), n0 + 1);

        // Back-to-back with queued character
        n0 = done_t.size();
        send(8'hA5);
        repeat (30) @(negedge clk);
        send(8'h3C);
        chk("b2b_ready_low", bus.o_ready, 0);
        wait_done(n0 + 2, 400);
        chk("b2b_gap", done_t[n0+1] - done_t[n0], 100);
        chk("b2b_b0", sent[sent.size()-2], 8'hA5);
        chk("b2b_b1", sent[sent.size()-1], 8'h3C);
        repeat (5) @(negedge clk);

        // Slow baud, switch back mid-frame
        n0 = done_t.size();
        baud = 1'b1;
        send(8'h00);
        n0 = n0;
        lowcnt = acc_cyc;
        repeat (300) @(negedge clk);
        baud = 1'b0;
        send(8'hFF);
        wait_done(n0 + 2, 2000);
        chk("slow_len", done_t[n0] - lowcnt, 1201);
        chk("slow_next_len", done_t[n0+1] - done_t[n0], 100);
        chk("slow_b1", sent[sent.size()-1], 8'hFF);
        repeat (5) @(negedge clk);

        // Backpressure stream with valid held high
        n0 = done_t.size();
        s4[0] = 8'h01; s4[1] = 8'h80; s4[2] = 8'hFF; s4[3] = 8'h00;
        stream(s4, 4);
        wait_done(n0 + 4, 800);
        for (int i = 1; i < 4; i++)
            chk("bp_gap", done_t[n0+i] - done_t[n0+i-1], 100);
        for (int i = 0; i < 4; i++)
            chk("bp_order", sent[sent.size()-4+i], s4[i]);
        repeat (5) @(negedge clk);
        chk("bp_no_extra", done_t.size(), n0 + 4);

        // Third byte presented while hold is full
        n0 = done_t.size();
        s4[0] = 8'h11; s4[1] = 8'h22; s4[2] = 8'h33; s4[3] = 8'h00;
        stream(s4, 3);
        wait_done(n0 + 3, 600);
        chk("ld_b0", sent[sent.size()-3], 8'h11);
        chk("ld_b1", sent[sent.size()-2], 8'h22);
        chk("ld_b2", sent[sent.size()-1], 8'h33);
        chk("ld_gap", done_t[n0+2] - done_t[n0+1], 100);
        repeat (5) @(negedge clk);

        // Reset mid-frame aborts the frame and the queue
        n0 = done_t.size();
        send(8'h55);
        send(8'h99);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_ready", bus.o_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        lowcnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lowcnt++;
        end
        chk("post_rst_idle", lowcnt, 0);
        chk("post_rst_nodone", done_t.size(), n0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
